// File: rtl/root_pkg.sv
// rtl/root_pkg.sv - Q10.10 format constants and FSM states shared by the root and power blocks
package root_pkg;

  localparam int FRAC_W  = 10;
  localparam int INT_W   = 10;
  localparam int MAX_EXP = 5;
  localparam int W       = INT_W + FRAC_W;
  localparam int ACC_W   = W * MAX_EXP;

  localparam logic [W-1:0] ONE = 20'h00400;
  localparam logic [W-1:0] SAT = 20'hFFFFF;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_MUL  = 2'd2,
    S_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/fixed_power_align.sv
// rtl/fixed_power_align.sv - aligns the exact k-fold product back to Q10.10 and flags overflow
module fixed_power_align
  import root_pkg::*;
#(
  parameter int FRAC_W  = root_pkg::FRAC_W,
  parameter int INT_W   = root_pkg::INT_W,
  parameter int MAX_EXP = root_pkg::MAX_EXP
) (
  input  logic [(INT_W+FRAC_W)*MAX_EXP-1:0] prod_i,
  input  logic [2:0]                        k_i,
  output logic [INT_W+FRAC_W-1:0]           data_o,
  output logic                              ovf_o
);

  localparam int PW = INT_W + FRAC_W;
  localparam int AW = PW * MAX_EXP;

  logic [AW-1:0] shifted;
  logic [AW-1:0] high;

  // Illegal exponents fall through to the saturated default.
  always_comb begin
    data_o  = {PW{1'b1}};
    ovf_o   = 1'b1;
    shifted = '0;
    high    = '0;
    if (k_i == 3'd0) begin
      data_o = PW'(1) << FRAC_W;
      ovf_o  = 1'b0;
    end else begin
      for (int i = 1; i <= MAX_EXP; i++) begin
        if (k_i == 3'(i)) begin
          shifted = prod_i >> (FRAC_W * (i - 1));
          high    = prod_i >> (FRAC_W * i + INT_W);
          ovf_o   = |high;
          data_o  = ovf_o ? {PW{1'b1}} : shifted[PW-1:0];
        end
      end
    end
  end

endmodule

// File: rtl/fixed_power.sv
// rtl/fixed_power.sv - iterative unsigned Q10.10 integer power x^k, one multiply per cycle
module fixed_power
  import root_pkg::*;
#(
  parameter int FRAC_W  = root_pkg::FRAC_W,
  parameter int INT_W   = root_pkg::INT_W,
  parameter int MAX_EXP = root_pkg::MAX_EXP
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  input  logic [INT_W+FRAC_W-1:0] in_data_1,
  input  logic [2:0]              in_data_2,
  output logic                    out_valid,
  output logic [INT_W+FRAC_W-1:0] out_data,
  output logic                    out_ovf
);

  localparam int PW = INT_W + FRAC_W;
  localparam int AW = PW * MAX_EXP;

  state_e        state_q, state_d;
  logic [PW-1:0] x_q, x_d;
  logic [2:0]    k_q, k_d;
  logic [AW-1:0] acc_q, acc_d;
  logic [2:0]    cnt_q, cnt_d;
  logic          out_valid_q, out_valid_d;
  logic [PW-1:0] out_data_q, out_data_d;
  logic          out_ovf_q, out_ovf_d;

  logic [PW-1:0] align_data;
  logic          align_ovf;
  logic [AW-1:0] x_ext;

  assign x_ext = AW'(x_q);

  fixed_power_align #(
    .FRAC_W  (FRAC_W),
    .INT_W   (INT_W),
    .MAX_EXP (MAX_EXP)
  ) u_align (
    .prod_i (acc_q),
    .k_i    (k_q),
    .data_o (align_data),
    .ovf_o  (align_ovf)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      x_q         <= '0;
      k_q         <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      k_q         <= k_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    k_d         = k_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    out_valid_d = 1'b0;
    out_data_d  = out_data_q;
    out_ovf_d   = out_ovf_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          x_d     = in_data_1;
          k_d     = in_data_2;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (in_valid) begin
          x_d = in_data_1;
          k_d = in_data_2;
        end else begin
          acc_d = x_ext;
          cnt_d = k_q - 3'd1;
          // Trivial and illegal exponents need no multiplies.
          if (k_q <= 3'd1 || 32'(k_q) > MAX_EXP) state_d = S_DONE;
          else                                   state_d = S_MUL;
        end
      end
      S_MUL: begin
        acc_d = acc_q * x_ext;
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) state_d = S_DONE;
      end
      S_DONE: begin
        out_valid_d = 1'b1;
        out_data_d  = align_data;
        out_ovf_d   = align_ovf;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_fixed_power.sv
// tb/tb_fixed_power.sv - scoreboard bench for fixed_power with directed hand-computed vectors
module tb_fixed_power;
  import root_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [19:0] in_data_1;
  logic [2:0]  in_data_2;
  logic        out_valid;
  logic [19:0] out_data;
  logic        out_ovf;

  fixed_power dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data_1 (in_data_1),
    .in_data_2 (in_data_2),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ovf   (out_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [19:0] d;
    logic        o;
    int          c;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  logic prev_v   = 1'b0;

  always @(posedge clk) cyc++;

  // Monitor: every out_valid must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (out_valid) begin
      checks++;
      if (prev_v) begin
        failures++;
        $display("FAIL pulse_width out_valid high two samples in a row at cyc=%0d, required single cycle", cyc);
      end
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_out data=%h ovf=%b at cyc=%0d, required no output", out_data, out_ovf, cyc);
      end else begin
        mon_e = sb.pop_front();
        if (out_data !== mon_e.d || out_ovf !== mon_e.o || cyc != mon_e.c) begin
          failures++;
          $display("FAIL result data=%h ovf=%b cyc=%0d, required data=%h ovf=%b cyc=%0d",
                   out_data, out_ovf, cyc, mon_e.d, mon_e.o, mon_e.c);
        end
      end
    end
    prev_v = out_valid;
  end

  function automatic int lat(input logic [2:0] k);
    return (k >= 3'd2 && k <= 3'd5) ? int'(k) : 1;
  endfunction

  // Called at a negedge; pre extra beats with junk data precede the final beat.
  task automatic send(input logic [19:0] x, input logic [2:0] k, input int pre,
                      input logic [19:0] ed, input logic eo, input bit push);
    exp_t e;
    for (int i = 0; i < pre; i++) begin
      in_valid  = 1'b1;
      in_data_1 = 20'h00123 + 20'(i);
      in_data_2 = 3'd4;
      @(negedge clk);
    end
    in_valid  = 1'b1;
    in_data_1 = x;
    in_data_2 = k;
    @(negedge clk);
    in_valid = 1'b0;
    e.d = ed;
    e.o = eo;
    e.c = cyc + 1 + lat(k);
    if (push) sb.push_back(e);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain_timeout pending=%0d, required 0", sb.size());
      sb.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_out();
    int n;
    n = 0;
    while (n < 40) begin
      @(negedge clk);
      if (out_valid) break;
      n++;
    end
    checks++;
    if (!out_valid) begin
      failures++;
      $display("FAIL wait_out_timeout out_valid=%b, required 1", out_valid);
    end
  endtask

  task automatic check_zero(input string name);
    checks++;
    if (out_valid !== 1'b0 || out_data !== 20'h0 || out_ovf !== 1'b0) begin
      failures++;
      $display("FAIL %s valid=%b data=%h ovf=%b, required 0/00000/0", name, out_valid, out_data, out_ovf);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data_1 = '0;
    in_data_2 = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check_zero("reset_state");

    send(20'h00800, 3'd3, 0, 20'h02000, 1'b0, 1'b1); wait_drain();
    send(20'h00401, 3'd2, 0, 20'h00402, 1'b0, 1'b1); wait_drain();
    send(20'h00600, 3'd2, 0, 20'h00900, 1'b0, 1'b1); wait_drain();
    send(20'h02800, 3'd3, 0, 20'hFA000, 1'b0, 1'b1); wait_drain();
    send(20'h00600, 3'd4, 0, 20'h01440, 1'b0, 1'b1); wait_drain();
    send(20'h0FC00, 3'd2, 0, SAT,       1'b1, 1'b1); wait_drain();
    send(20'h00800, 3'd7, 0, SAT,       1'b1, 1'b1); wait_drain();
    send(20'h00800, 3'd6, 0, SAT,       1'b1, 1'b1); wait_drain();
    send(20'hFFFFF, 3'd1, 0, 20'hFFFFF, 1'b0, 1'b1); wait_drain();
    send(20'h00000, 3'd0, 0, ONE,       1'b0, 1'b1); wait_drain();

    // Three-beat input with changing data: only the last beat counts.
    send(20'h00C00, 3'd2, 2, 20'h02400, 1'b0, 1'b1); wait_drain();

    // Back-to-back: next request issued in the cycle out_valid is high.
    send(20'h00600, 3'd2, 0, 20'h00900, 1'b0, 1'b1);
    wait_out();
    send(20'h00C00, 3'd3, 0, 20'h06C00, 1'b0, 1'b1);
    wait_drain();

    // in_valid pulsed while multiplying must be ignored.
    send(20'h00800, 3'd5, 0, 20'h08000, 1'b0, 1'b1);
    @(negedge clk);
    in_valid  = 1'b1;
    in_data_1 = 20'h00C00;
    in_data_2 = 3'd2;
    repeat (2) @(negedge clk);
    in_valid = 1'b0;
    wait_drain();
    checks++;
    if (dut.state_q !== S_IDLE) begin
      failures++;
      $display("FAIL busy_ignored state=%0d, required IDLE", dut.state_q);
    end

    // Reset in the middle of a k=5 computation discards it.
    send(20'h00800, 3'd5, 0, 20'h0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_zero("reset_mid_mul");
    repeat (12) @(negedge clk);
    send(20'h00C00, 3'd2, 0, 20'h02400, 1'b0, 1'b1); wait_drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
